// File: rtl/led_seq_pkg.sv
// Shared types, mode/seed constants and pattern arithmetic for the LED PIO sequencer.
// Patterns are carried in bus-width words so one function set serves any LED width.
package led_seq_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] MODE_WALK_L = 2'd0;
    localparam logic [1:0] MODE_WALK_R = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_WAIT = 2'd3
    } seq_state_t;

    localparam logic [BUS_W-1:0] SEED_WALK  = 32'h0000_0001;
    localparam logic [BUS_W-1:0] SEED_COUNT = 32'h0000_0000;

    function automatic logic [BUS_W-1:0] width_mask(input int width);
        return (BUS_W'(1) << width) - BUS_W'(1);
    endfunction

    // Blink starts with every LED lit, so its seed depends on the LED width.
    function automatic logic [BUS_W-1:0] seed_pattern(input logic [1:0] mode, input int width);
        case (mode)
            MODE_BLINK: return width_mask(width);
            MODE_COUNT: return SEED_COUNT;
            default:    return SEED_WALK;
        endcase
    endfunction

    function automatic logic [BUS_W-1:0] next_pattern(input logic [1:0] mode,
                                                      input logic [BUS_W-1:0] pattern,
                                                      input int width);
        logic [BUS_W-1:0] mask;
        mask = width_mask(width);
        case (mode)
            MODE_WALK_L: return ((pattern << 1) | (pattern >> (width - 1))) & mask;
            MODE_WALK_R: return ((pattern >> 1) | (pattern << (width - 1))) & mask;
            MODE_BLINK:  return ~pattern & mask;
            default:     return (pattern + BUS_W'(1)) & mask;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Avalon-MM slave port of the LED PIO as seen from the sequencer (master) side.
interface led_seq_if;
    import led_seq_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts while run is high and pulses tick on the terminal count.
// The compare is against the live period, so shrinking it below the count ends the wait at once.
module led_seq_prescaler
#(
    parameter int PER_W = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] count_reg;
    logic [PER_W-1:0] count_next;
    logic [PER_W-1:0] limit;

    // A period of 0 behaves like 1, i.e. terminal count 0.
    assign limit = (period == '0) ? '0 : period - PER_W'(1);
    assign tick  = run && (count_reg >= limit);

    always_comb begin
        count_next = count_reg;
        if (!run || tick) begin
            count_next = '0;
        end else begin
            count_next = count_reg + PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM master that writes a pattern to the LED PIO every step, reads it back
// and raises a sticky error when the readback disagrees.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W  = 4,
    parameter int PER_W  = 26,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [PER_W-1:0]  period,
    input  logic              err_clr,
    led_seq_if.master         bus,
    output logic              busy,
    output logic              err,
    output logic [STEP_W-1:0] step_cnt
);

    seq_state_t        state_reg, state_next;
    logic [LED_W-1:0]  pattern_reg, pattern_next;
    logic [1:0]        mode_used_reg, mode_used_next;
    logic [BUS_W-1:0]  writedata_reg, writedata_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic              err_reg, err_next;
    logic              chipselect_reg;
    logic              write_n_reg;
    logic              busy_reg;
    logic              run;
    logic              tick;
    logic              mismatch;
    logic [BUS_W-1:0]  pattern_calc;
    logic              unused_hi;

    assign run = (state_reg == ST_WAIT) && enable;

    led_seq_prescaler #(
        .PER_W (PER_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .period  (period),
        .tick    (tick)
    );

    // A mode change since the last write restarts from that mode's seed instead of advancing.
    always_comb begin
        if (mode != mode_used_reg) begin
            pattern_calc = seed_pattern(mode, LED_W);
        end else begin
            pattern_calc = next_pattern(mode_used_reg, BUS_W'(pattern_reg), LED_W);
        end
    end

    assign unused_hi = ^{pattern_calc[BUS_W-1:LED_W], bus.readdata[BUS_W-1:LED_W]};
    assign mismatch  = (state_reg == ST_RD) && (bus.readdata[LED_W-1:0] != pattern_reg);

    always_comb begin
        state_next     = state_reg;
        pattern_next   = pattern_reg;
        mode_used_next = mode_used_reg;
        writedata_next = writedata_reg;
        step_next      = step_reg;
        err_next       = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable) state_next = ST_WR;
            end
            ST_WR: begin
                state_next = ST_RD;
            end
            ST_RD: begin
                state_next = enable ? ST_WAIT : ST_IDLE;
                step_next  = step_reg + STEP_W'(1);
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    state_next   = ST_WR;
                    pattern_next = pattern_calc[LED_W-1:0];
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Record the mode that accompanies each write; it decides seed-vs-advance next time.
        if (state_next == ST_WR) begin
            mode_used_next = mode;
            writedata_next = BUS_W'(pattern_next);
        end
        if (mismatch) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    // Bus strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            pattern_reg    <= LED_W'(SEED_WALK);
            mode_used_reg  <= MODE_WALK_L;
            writedata_reg  <= '0;
            step_reg       <= '0;
            err_reg        <= 1'b0;
            chipselect_reg <= 1'b0;
            write_n_reg    <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pattern_reg    <= pattern_next;
            mode_used_reg  <= mode_used_next;
            writedata_reg  <= writedata_next;
            step_reg       <= step_next;
            err_reg        <= err_next;
            chipselect_reg <= (state_next == ST_WR) || (state_next == ST_RD);
            write_n_reg    <= (state_next != ST_WR);
            busy_reg       <= (state_next != ST_IDLE);
        end
    end

    assign bus.address    = 2'b00;
    assign bus.chipselect = chipselect_reg;
    assign bus.write_n    = write_n_reg;
    assign bus.writedata  = writedata_reg;
    assign busy           = busy_reg;
    assign err            = err_reg;
    assign step_cnt       = step_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus random stimulus,
// compared every cycle against a step-level behavioural model of the sequencer and PIO.
module tb_led_pattern_sequencer;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic        enable   = 1'b0;
    logic [1:0]  mode     = 2'd0;
    logic [25:0] period   = 26'd1;
    logic        err_clr  = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] step_cnt;
    logic [3:0]  pio_reg  = 4'h0;
    int          read_idx = 0;
    int          force_idx = -1;
    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        corrupt;
    logic [31:0] wr_d[$];
    int          wr_t[$];

    led_seq_if bus ();

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .LED_W  (4),
        .PER_W  (26),
        .STEP_W (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .mode     (mode),
        .period   (period),
        .err_clr  (err_clr),
        .bus      (bus),
        .busy     (busy),
        .err      (err),
        .step_cnt (step_cnt)
    );

    // PIO model: latches writes, returns its value with junk in the unused upper bits.
    assign corrupt      = bus.chipselect && bus.write_n && (read_idx == force_idx);
    assign bus.readdata = {28'hBEEF123, corrupt ? 4'h0 : pio_reg};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.chipselect && !bus.write_n) pio_reg <= bus.writedata[3:0];
        if (bus.chipselect && bus.write_n) read_idx <= read_idx + 1;
    end

    // Behavioural model: phase 0 idle, 1 write, 2 read/check, 3 waiting out the period.
    typedef struct {
        int         phase;
        int         wait_cnt;
        int         steps;
        logic [3:0] pat;
        logic [3:0] pio;
        logic [3:0] wdata;
        logic [1:0] mode_used;
        logic       err;
    } model_t;

    model_t m;

    function automatic logic [3:0] seed_of(input logic [1:0] md);
        if (md == 2'd2) return 4'hF;
        if (md == 2'd3) return 4'h0;
        return 4'h1;
    endfunction

    function automatic logic [3:0] advance(input logic [1:0] md, input logic [3:0] p);
        int v;
        v = int'(p);
        case (md)
            2'd0:    v = (v * 2) % 16 + v / 8;
            2'd1:    v = v / 2 + (v % 2) * 8;
            2'd2:    v = 15 - v;
            default: v = (v + 1) % 16;
        endcase
        return 4'(v);
    endfunction

    function automatic model_t model_step(input model_t s, input logic en, input logic [1:0] md,
                                          input int per, input logic clr, input logic bad_rd);
        model_t n;
        int     lim;
        n   = s;
        lim = (per == 0) ? 1 : per;
        if (clr) n.err = 1'b0;
        case (s.phase)
            0: begin
                if (en) begin
                    n.phase     = 1;
                    n.mode_used = md;
                    n.wdata     = s.pat;
                end
            end
            1: begin
                n.pio   = s.wdata;
                n.phase = 2;
            end
            2: begin
                if ((bad_rd ? 4'h0 : s.pio) != s.pat) n.err = 1'b1;
                n.steps    = (s.steps + 1) % 65536;
                n.phase    = en ? 3 : 0;
                n.wait_cnt = 0;
            end
            default: begin
                if (!en) begin
                    n.phase    = 0;
                    n.wait_cnt = 0;
                end else if (s.wait_cnt + 1 >= lim) begin
                    n.pat       = (md != s.mode_used) ? seed_of(md) : advance(s.mode_used, s.pat);
                    n.mode_used = md;
                    n.wdata     = n.pat;
                    n.phase     = 1;
                    n.wait_cnt  = 0;
                end else begin
                    n.wait_cnt = s.wait_cnt + 1;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m.phase     <= 0;
            m.wait_cnt  <= 0;
            m.steps     <= 0;
            m.pat       <= 4'h1;
            m.wdata     <= 4'h0;
            m.mode_used <= 2'd0;
            m.err       <= 1'b0;
        end else begin
            m <= model_step(m, enable, mode, int'(period), err_clr, corrupt);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Advance one clock; compare every DUT output with the model away from the active edge.
    task automatic tick();
        logic        e_busy, e_cs, e_wn;
        logic [31:0] e_wd;
        @(negedge clk);
        if (reset_n) begin
            e_busy = (m.phase != 0);
            e_cs   = (m.phase == 1) || (m.phase == 2);
            e_wn   = (m.phase != 1);
            e_wd   = {28'h0, m.wdata};
            checks++;
            if (busy !== e_busy || bus.chipselect !== e_cs || bus.write_n !== e_wn ||
                bus.address !== 2'b00 || bus.writedata !== e_wd || err !== m.err ||
                step_cnt !== 16'(m.steps)) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d got busy=%b cs=%b wn=%b addr=%0d wd=%h err=%b steps=%0d required busy=%b cs=%b wn=%b addr=0 wd=%h err=%b steps=%0d",
                         cyc, busy, bus.chipselect, bus.write_n, bus.address, bus.writedata, err, step_cnt,
                         e_busy, e_cs, e_wn, e_wd, m.err, 16'(m.steps));
            end
            if (bus.chipselect && !bus.write_n) begin
                wr_d.push_back(bus.writedata);
                wr_t.push_back(cyc);
                $display("write cyc=%0d data=%h mode=%0d period=%0d step_cnt=%0d err=%b",
                         cyc, bus.writedata, mode, period, step_cnt, err);
            end
        end
        #1;
    endtask

    task automatic wait_writes(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wr_d.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("write_timeout", 32'(wr_d.size() - base), 32'(n));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        err_clr   = 1'b0;
        mode      = 2'd0;
        period    = 26'd1;
        force_idx = -1;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cs", 32'(bus.chipselect), 32'h0);
        check("rst_wn", 32'(bus.write_n), 32'h1);
        check("rst_wd", bus.writedata, 32'h0);
        check("rst_err_steps", {15'h0, err, step_cnt}, 32'h0);
    endtask

    task automatic check_seq(input string name, input int base, input int gap,
                             input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] exp_v[3];
        exp_v[0] = a;
        exp_v[1] = b;
        exp_v[2] = c;
        for (int i = 0; i < 3; i++) begin
            check(name, wr_d[base + i], {28'h0, exp_v[i]});
            if (i > 0 && gap > 0) check({name, "_gap"}, 32'(wr_t[base + i] - wr_t[base + i - 1]), 32'(gap));
        end
    endtask

    initial begin
        int         base;
        int         c0;
        bit         ok;
        logic [3:0] exp1[5];
        exp1[0] = 4'b0001;
        exp1[1] = 4'b0010;
        exp1[2] = 4'b0100;
        exp1[3] = 4'b1000;
        exp1[4] = 4'b0001;
        #2;

        // Walk-left at period 3: five writes five clocks apart.
        do_reset();
        mode = 2'd0; period = 26'd3; enable = 1'b1;
        c0 = cyc; base = wr_d.size();
        wait_writes(base, 5, ok);
        if (ok) begin
            check("t1_first_latency", 32'(wr_t[base] - c0), 32'd1);
            for (int i = 0; i < 5; i++) begin
                check("t1_data", wr_d[base + i], {28'h0, exp1[i]});
                if (i > 0) check("t1_gap", 32'(wr_t[base + i] - wr_t[base + i - 1]), 32'd5);
            end
            tick(); tick();
            check("t1_steps", 32'(step_cnt), 32'd5);
            check("t1_err", 32'(err), 32'd0);
        end

        // Walk-right with period 0 behaving as 1.
        do_reset();
        mode = 2'd1; period = 26'd0; enable = 1'b1;
        base = wr_d.size();
        wait_writes(base, 3, ok);
        if (ok) check_seq("t2_walk_r", base, 3, 4'b0001, 4'b1000, 4'b0100);

        // Mode changes reseed: walk -> blink -> count.
        do_reset();
        mode = 2'd0; period = 26'd2; enable = 1'b1;
        base = wr_d.size();
        wait_writes(base, 3, ok);
        if (ok) begin
            check("t3_pre", wr_d[base + 2], 32'h4);
            mode = 2'd2;
            wait_writes(base + 3, 3, ok);
            if (ok) begin
                check_seq("t3_blink", base + 3, 4, 4'b1111, 4'b0000, 4'b1111);
                mode = 2'd3;
                wait_writes(base + 6, 3, ok);
                if (ok) check_seq("t3_count", base + 6, 4, 4'b0000, 4'b0001, 4'b0010);
            end
        end

        // Readback mismatch, sticky err, err_clr and clear-vs-mismatch priority.
        do_reset();
        mode = 2'd0; period = 26'd2; enable = 1'b1;
        force_idx = read_idx + 2;
        base = wr_d.size();
        wait_writes(base, 3, ok);
        if (ok) begin
            tick(); tick();
            check("t4_err_set", 32'(err), 32'd1);
            check("t4_steps", 32'(step_cnt), 32'd3);
            repeat (5) tick();
            check("t4_err_sticky", 32'(err), 32'd1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("t4_err_cleared", 32'(err), 32'd0);
            force_idx = read_idx + 1;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (corrupt) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check("t4_find_bad_read", 32'(ok), 32'd1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("t4_clr_vs_mismatch", 32'(err), 32'd1);
            tick(); tick();
            check("t4_err_after", 32'(err), 32'd1);
        end

        // Drop enable during WR: read and check still complete, then idle; resume rewrites.
        do_reset();
        mode = 2'd0; period = 26'd4; enable = 1'b1;
        base = wr_d.size();
        wait_writes(base, 1, ok);
        if (ok) begin
            enable = 1'b0;
            tick();
            check("t5_rd_cs", 32'(bus.chipselect), 32'd1);
            check("t5_rd_wn", 32'(bus.write_n), 32'd1);
            tick();
            check("t5_steps", 32'(step_cnt), 32'd1);
            check("t5_busy", 32'(busy), 32'd0);
            check("t5_cs", 32'(bus.chipselect), 32'd0);
            repeat (3) tick();
            base = wr_d.size(); c0 = cyc;
            enable = 1'b1;
            tick();
            check("t5_rewrite_seen", 32'(wr_d.size() - base), 32'd1);
            if (wr_d.size() > base) begin
                check("t5_rewrite_data", wr_d[base], 32'h1);
                check("t5_rewrite_time", 32'(wr_t[base] - c0), 32'd1);
            end
        end

        // Asynchronous reset in the middle of a read cycle.
        do_reset();
        mode = 2'd0; period = 26'd2; enable = 1'b1;
        force_idx = read_idx;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.chipselect && bus.write_n && step_cnt >= 16'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_reach_rd", 32'(ok), 32'd1);
        check("t6_err_pre", 32'(err), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_cs", 32'(bus.chipselect), 32'd0);
        check("t6_async_wn", 32'(bus.write_n), 32'd1);
        check("t6_async_err", 32'(err), 32'd0);
        check("t6_async_steps", 32'(step_cnt), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        tick();
        force_idx = -1;
        reset_n = 1'b1;
        base = wr_d.size(); c0 = cyc;
        tick();
        check("t6_restart_seen", 32'(wr_d.size() - base), 32'd1);
        if (wr_d.size() > base) check("t6_restart_data", wr_d[base], 32'h1);

        // Random enable/mode/period/err_clr/corruption against the model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int n;
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            period  = 26'($urandom_range(0, 5));
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) force_idx = read_idx + int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 8));
            tick();
            err_clr = 1'b0;
            for (int k = 1; k < n; k++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
